input_port_ctrl: RTL and testbench
==================================

# input_port_ctrl

Router input-port controller: the requesting side of the switch-allocator handshake. It buffers incoming flits in a small FIFO and computes the XY route from each head flit. It then requests the computed output port, holds the request until granted, and streams the packet's flits through the crossbar. After the tail flit it pulses CROSS_DONE so the allocator moves on. One instance per router input (W, E, N, S, PE).

## Interface
- FLIT_W, 16, flit width; bits [FLIT_W-1:FLIT_W-2] are flit type
- DEPTH, 4, FIFO depth in flits (power of 2, ≥2)
- COORD_W, 2, width of each X/Y coordinate
- X_CUR, 0, this router's X coordinate
- Y_CUR, 0, this router's Y coordinate
- REQ_size, 3, output-port code width
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  upstream flit valid
- IN_FLIT  in  FLIT_W  upstream flit
- IN_READY  out  1  FIFO not full
- REQ_VALID  out  1  request to allocator
- REQ_SW  out  REQ_size  requested output: 000 W, 001 E, 010 N, 011 S, 100 PE
- GRANT  in  1  allocator grant for this port
- OUT_FLIT  out  FLIT_W  flit to crossbar (FIFO head)
- OUT_VALID  out  1  OUT_FLIT valid this cycle
- OUT_READY  in  1  downstream accepts flit
- CROSS_DONE  out  1  one-cycle pulse after tail flit leaves
- ERR_DROP  out  1  one-cycle pulse when a malformed flit is discarded
- ERR_CNT  out  8  dropped-flit count

## Operation
- Flit types: 01 head, 00 body, 10 tail, 11 single (head+tail). Head/single carry dest X in [2*COORD_W-1:COORD_W] and dest Y in [COORD_W-1:0].
- XY routing: DX>X_CUR → E; DX<X_CUR → W; else DY>Y_CUR → N; DY<Y_CUR → S; else PE.
- FIFO push when IN_VALID && IN_READY. IN_READY = !full (no push when full, even with a pop in the same cycle). Pop when OUT_VALID && OUT_READY.
- FSM states:
  - IDLE: if FIFO non-empty and head type is 01/11 → ROUTE. If head type is 00/10, pop it, pulse ERR_DROP, and stay in IDLE.
  - ROUTE: register REQ_SW from the FIFO head → REQ.
  - REQ: REQ_VALID=1; GRANT sampled 1 → XFER.
  - XFER: REQ_VALID=1; OUT_VALID = GRANT && !empty. On a pop of a tail/single flit → DONE, else stay.
  - DONE: CROSS_DONE=1, REQ_VALID=0, OUT_VALID=0 → IDLE.
- GRANT dropping in XFER stalls output; the FSM stays in XFER with REQ_VALID held.
- REQ_SW is stable from REQ entry until IDLE.
- Reset (any time): state IDLE, FIFO pointers/count 0, REQ_SW=000, ERR_CNT=0. All outputs 0 except IN_READY=1. Reset mid-packet discards buffered flits.

## Timing
- Flit written at edge k: FSM enters ROUTE at edge k+1 and REQ at edge k+2. REQ_VALID is high in the cycle after edge k+2.
- GRANT high in cycle c → XFER at edge c+1; first OUT_VALID in cycle c+1.
- Throughput of one flit per cycle while GRANT, OUT_READY and FIFO non-empty hold.
- Tail popped at edge t → CROSS_DONE high for exactly cycle t+1 → IDLE at edge t+2. Minimum gap between packets is 3 cycles (IDLE, ROUTE, REQ).
- OUT_FLIT, OUT_VALID, REQ_VALID and CROSS_DONE are functions of registered state and FIFO head only. They have no combinational path from IN_*.

## Configuration
- IPC_ERR_CNT_EN defined: ERR_CNT is an 8-bit saturating counter, +1 per ERR_DROP, held at 255.
- IPC_ERR_CNT_EN undefined: no counter logic; ERR_CNT is tied to 0. ERR_DROP and drop behaviour are unchanged.

## Test plan
- Reset: hold RST=0 with random inputs → all outputs 0, IN_READY=1; after release, no REQ_VALID with an empty FIFO.
- X_CUR=1, Y_CUR=1; single flit 16'hC009 (type 11, dest 2,1) → REQ_SW=001 and REQ_VALID 2 cycles after write. With GRANT=1: OUT_VALID for 1 cycle with OUT_FLIT=C009, then CROSS_DONE for 1 cycle, then IDLE.
- 3-flit packet (head dest 1,1 / body / tail), GRANT=1, OUT_READY=0 for one cycle on the body → REQ_SW=100. Body is held one cycle; 3 pops total; CROSS_DONE exactly once, after the tail.
- GRANT=0, push 4 flits → IN_READY=0 after the 4th; a 5th IN_VALID is not stored. Raise GRANT → IN_READY=1 after the first pop.
- Body flit at head in IDLE → popped, ERR_DROP for 1 cycle, ERR_CNT=1 (0 without macro). After 300 drops, ERR_CNT=255.
- RST asserted mid-XFER → outputs 0, FIFO empty, IN_READY=1. The next packet routes normally.

Source files
------------

// File: rtl/input_port_ctrl.sv
`timescale 1ns/1ps
// input_port_ctrl: router input port with a flit FIFO, XY route computation and the
// switch-allocator request/transfer FSM. Define IPC_ERR_CNT_EN to enable the saturating ERR_CNT.
module input_port_ctrl #(
  parameter int FLIT_W   = 16,
  parameter int DEPTH    = 4,
  parameter int COORD_W  = 2,
  parameter int X_CUR    = 0,
  parameter int Y_CUR    = 0,
  parameter int REQ_size = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  input  logic [FLIT_W-1:0]   IN_FLIT,
  output logic                IN_READY,
  output logic                REQ_VALID,
  output logic [REQ_size-1:0] REQ_SW,
  input  logic                GRANT,
  output logic [FLIT_W-1:0]   OUT_FLIT,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                CROSS_DONE,
  output logic                ERR_DROP,
  output logic [7:0]          ERR_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_W-1:0]  X_HERE  = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0]  Y_HERE  = COORD_W'(Y_CUR);
  localparam logic [REQ_size-1:0] PORT_W  = REQ_size'(0);
  localparam logic [REQ_size-1:0] PORT_E  = REQ_size'(1);
  localparam logic [REQ_size-1:0] PORT_N  = REQ_size'(2);
  localparam logic [REQ_size-1:0] PORT_S  = REQ_size'(3);
  localparam logic [REQ_size-1:0] PORT_PE = REQ_size'(4);

  typedef enum logic [2:0] {ST_IDLE, ST_ROUTE, ST_REQ, ST_XFER, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic [FLIT_W-1:0]   mem_reg [DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         count_reg;
  logic [REQ_size-1:0] req_sw_reg, req_sw_next;
  logic                empty, full, push, pop;
  logic [FLIT_W-1:0]   head;
  logic [1:0]          head_type;
  logic [COORD_W-1:0]  head_dx, head_dy;
  logic [REQ_size-1:0] route_sw;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push      = IN_VALID && !full;
  assign head      = mem_reg[rd_ptr_reg];
  assign head_type = head[FLIT_W-1 -: 2];
  assign head_dx   = head[2*COORD_W-1 -: COORD_W];
  assign head_dy   = head[COORD_W-1:0];

  assign IN_READY = !full;
  assign REQ_SW   = req_sw_reg;
  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign OUT_FLIT = empty ? '0 : head;

  always_ff @(posedge CLK) begin
    if (push) mem_reg[wr_ptr_reg] <= IN_FLIT;
  end

  // Dimension-ordered routing: resolve X first, then Y.
  always_comb begin
    route_sw = PORT_PE;
    if (head_dx > X_HERE)      route_sw = PORT_E;
    else if (head_dx < X_HERE) route_sw = PORT_W;
    else if (head_dy > Y_HERE) route_sw = PORT_N;
    else if (head_dy < Y_HERE) route_sw = PORT_S;
  end

  always_comb begin
    state_next  = state_reg;
    req_sw_next = req_sw_reg;
    REQ_VALID   = 1'b0;
    OUT_VALID   = 1'b0;
    CROSS_DONE  = 1'b0;
    ERR_DROP    = 1'b0;
    pop         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          if (head_type[0]) begin
            state_next = ST_ROUTE;
          end else begin
            pop      = 1'b1;
            ERR_DROP = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        req_sw_next = route_sw;
        state_next  = ST_REQ;
      end
      ST_REQ: begin
        REQ_VALID = 1'b1;
        if (GRANT) state_next = ST_XFER;
      end
      ST_XFER: begin
        REQ_VALID = 1'b1;
        OUT_VALID = GRANT && !empty;
        pop       = OUT_VALID && OUT_READY;
        if (pop && head_type[1]) state_next = ST_DONE;
      end
      ST_DONE: begin
        CROSS_DONE = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      req_sw_reg <= '0;
    end else begin
      state_reg  <= state_next;
      req_sw_reg <= req_sw_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef IPC_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_reg <= '0;
    end else if (ERR_DROP && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt_reg;
`else
  assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
`timescale 1ns/1ps
// tb_input_port_ctrl: directed vector table, corner-case sequences and a randomized
// packet stream scored against a transaction-level model of the input port.
module tb_input_port_ctrl;
  localparam int FW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [FW-1:0] IN_FLIT = '0;
  logic          GRANT = 1'b0;
  logic          OUT_READY = 1'b0;
  logic          IN_READY, REQ_VALID, OUT_VALID, CROSS_DONE, ERR_DROP;
  logic [2:0]    REQ_SW;
  logic [FW-1:0] OUT_FLIT;
  logic [7:0]    ERR_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  input_port_ctrl #(
    .FLIT_W(FW), .DEPTH(4), .COORD_W(2), .X_CUR(1), .Y_CUR(1), .REQ_size(3)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_FLIT(IN_FLIT), .IN_READY(IN_READY),
    .REQ_VALID(REQ_VALID), .REQ_SW(REQ_SW), .GRANT(GRANT), .OUT_FLIT(OUT_FLIT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CROSS_DONE(CROSS_DONE),
    .ERR_DROP(ERR_DROP), .ERR_CNT(ERR_CNT)
  );

  typedef struct {
    logic        in_valid;
    logic [15:0] in_flit;
    logic        grant;
    logic        out_ready;
    logic        in_ready;
    logic        req_valid;
    logic [2:0]  req_sw;
    logic        out_valid;
    logic [15:0] out_flit;
    logic        cross_done;
    logic        err_drop;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic iv, input logic [15:0] f, input logic g, input logic r,
                              input logic rdy, input logic rv, input logic [2:0] sw,
                              input logic ov, input logic [15:0] of, input logic cd, input logic ed);
    vec_t v;
    v.in_valid = iv; v.in_flit = f; v.grant = g; v.out_ready = r;
    v.in_ready = rdy; v.req_valid = rv; v.req_sw = sw; v.out_valid = ov;
    v.out_flit = of; v.cross_done = cd; v.err_drop = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // XY routing as a plain rule on this router's position (1,1).
  function automatic logic [2:0] xy_route(input int dx, input int dy);
    if (dx > 1) return 3'd1;
    if (dx < 1) return 3'd0;
    if (dy > 1) return 3'd2;
    if (dy < 1) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [7:0] exp_cnt(input int n);
    logic [7:0] r;
    r = (n > 255) ? 8'd255 : 8'(n);
`ifndef IPC_ERR_CNT_EN
    r = 8'd0;
`endif
    return r;
  endfunction

  function automatic logic sel(input int w);
    case (w)
      0:       return REQ_VALID;
      1:       return OUT_VALID;
      default: return CROSS_DONE;
    endcase
  endfunction

  // Returns at the negedge where the selected output is high, or reports a timeout.
  task automatic wait_sig(input int w, input string name);
    checks++;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (sel(w)) return;
      @(posedge CLK); #1;
    end
    errors++;
    $display("FAIL %s: got timeout expected event within 20 cycles", name);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " in_ready"},   32'(IN_READY),   32'd1);
    chk({tag, " req_valid"},  32'(REQ_VALID),  32'd0);
    chk({tag, " out_valid"},  32'(OUT_VALID),  32'd0);
    chk({tag, " out_flit"},   32'(OUT_FLIT),   32'd0);
    chk({tag, " cross_done"}, 32'(CROSS_DONE), 32'd0);
    chk({tag, " err_drop"},   32'(ERR_DROP),   32'd0);
  endtask

  initial begin
    logic [15:0] got[$];
    logic [15:0] stream[$];
    logic [15:0] exp_flits[$];
    logic [2:0]  exp_route[$];
    int          drops;

    // ---------------- reset with random inputs ----------------
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'($urandom); IN_FLIT = 16'($urandom);
      GRANT = 1'($urandom); OUT_READY = 1'($urandom);
      @(negedge CLK);
      check_idle_outputs($sformatf("rst%0d", i));
      chk($sformatf("rst%0d req_sw", i), 32'(REQ_SW), 32'd0);
      chk($sformatf("rst%0d err_cnt", i), 32'(ERR_CNT), 32'd0);
      $display("reset cycle %0d checked", i);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0; GRANT = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d req_valid", i), 32'(REQ_VALID), 32'd0);
      @(posedge CLK); #1;
    end

    // ---------------- vector table: single flit, then 3-flit packet ----------------
    vecs[0]  = mk(1, 16'hC009, 0, 1,  1, 0, 3'd0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 16'h0000, 1, 1,  1, 0, 3'd0, 0, 16'hC009, 0, 0);
    vecs[2]  = mk(0, 16'h0000, 1, 1,  1, 0, 3'd0, 0, 16'hC009, 0, 0);
    vecs[3]  = mk(0, 16'h0000, 1, 1,  1, 1, 3'd1, 0, 16'hC009, 0, 0);
    vecs[4]  = mk(0, 16'h0000, 1, 1,  1, 1, 3'd1, 1, 16'hC009, 0, 0);
    vecs[5]  = mk(0, 16'h0000, 1, 1,  1, 0, 3'd1, 0, 16'h0000, 1, 0);
    vecs[6]  = mk(0, 16'h0000, 1, 1,  1, 0, 3'd1, 0, 16'h0000, 0, 0);
    vecs[7]  = mk(1, 16'h4005, 1, 1,  1, 0, 3'd1, 0, 16'h0000, 0, 0);
    vecs[8]  = mk(1, 16'h0123, 1, 1,  1, 0, 3'd1, 0, 16'h4005, 0, 0);
    vecs[9]  = mk(1, 16'h8456, 1, 1,  1, 0, 3'd1, 0, 16'h4005, 0, 0);
    vecs[10] = mk(0, 16'h0000, 1, 1,  1, 1, 3'd4, 0, 16'h4005, 0, 0);
    vecs[11] = mk(0, 16'h0000, 1, 1,  1, 1, 3'd4, 1, 16'h4005, 0, 0);
    vecs[12] = mk(0, 16'h0000, 1, 0,  1, 1, 3'd4, 1, 16'h0123, 0, 0);
    vecs[13] = mk(0, 16'h0000, 1, 1,  1, 1, 3'd4, 1, 16'h0123, 0, 0);
    vecs[14] = mk(0, 16'h0000, 1, 1,  1, 1, 3'd4, 1, 16'h8456, 0, 0);
    vecs[15] = mk(0, 16'h0000, 1, 1,  1, 0, 3'd4, 0, 16'h0000, 1, 0);
    vecs[16] = mk(0, 16'h0000, 1, 1,  1, 0, 3'd4, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 17; i++) begin
      IN_VALID = vecs[i].in_valid; IN_FLIT = vecs[i].in_flit;
      GRANT = vecs[i].grant; OUT_READY = vecs[i].out_ready;
      @(negedge CLK);
      chk($sformatf("v%0d in_ready", i),   32'(IN_READY),   32'(vecs[i].in_ready));
      chk($sformatf("v%0d req_valid", i),  32'(REQ_VALID),  32'(vecs[i].req_valid));
      chk($sformatf("v%0d req_sw", i),     32'(REQ_SW),     32'(vecs[i].req_sw));
      chk($sformatf("v%0d out_valid", i),  32'(OUT_VALID),  32'(vecs[i].out_valid));
      chk($sformatf("v%0d out_flit", i),   32'(OUT_FLIT),   32'(vecs[i].out_flit));
      chk($sformatf("v%0d cross_done", i), 32'(CROSS_DONE), 32'(vecs[i].cross_done));
      chk($sformatf("v%0d err_drop", i),   32'(ERR_DROP),   32'(vecs[i].err_drop));
      $display("vector %0d in_valid=%0b flit=%h grant=%0b ready=%0b", i,
               vecs[i].in_valid, vecs[i].in_flit, vecs[i].grant, vecs[i].out_ready);
      @(posedge CLK); #1;
    end

    // ---------------- FIFO full with GRANT low ----------------
    GRANT = 1'b0; OUT_READY = 1'b1;
    stream = '{16'h4001, 16'h0111, 16'h0222, 16'h8333};
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; IN_FLIT = stream[i];
      @(negedge CLK);
      chk($sformatf("full push%0d in_ready", i), 32'(IN_READY), 32'd1);
      @(posedge CLK); #1;
    end
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1; IN_FLIT = 16'h0BAD;
      @(negedge CLK);
      chk($sformatf("full%0d in_ready", i), 32'(IN_READY), 32'd0);
      chk($sformatf("full%0d req_valid", i), 32'(REQ_VALID), 32'd1);
      chk($sformatf("full%0d req_sw", i), 32'(REQ_SW), 32'(xy_route(0, 1)));
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0; GRANT = 1'b1;
    @(negedge CLK);
    chk("full grant out_valid", 32'(OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("full xfer out_valid", 32'(OUT_VALID), 32'd1);
    chk("full xfer out_flit", 32'(OUT_FLIT), 32'h4001);
    chk("full xfer in_ready", 32'(IN_READY), 32'd0);
    @(posedge CLK); #1;
    got.delete();
    begin
      bit seen_done = 0;
      for (int i = 0; i < 10 && !seen_done; i++) begin
        @(negedge CLK);
        if (i == 0) chk("full after pop in_ready", 32'(IN_READY), 32'd1);
        if (OUT_VALID && OUT_READY) got.push_back(OUT_FLIT);
        if (CROSS_DONE) seen_done = 1;
        @(posedge CLK); #1;
      end
      chk("full cross_done seen", 32'(seen_done), 32'd1);
    end
    chk("full pop count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("full flit%0d", i + 1), 32'(got[i]), 32'(stream[i + 1]));
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle_outputs($sformatf("full tail%0d", i));
      @(posedge CLK); #1;
    end
    $display("full-FIFO sequence done, %0d flits after head", got.size());

    // ---------------- malformed head drop ----------------
    IN_VALID = 1'b1; IN_FLIT = 16'h0077;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("drop err_drop", 32'(ERR_DROP), 32'd1);
    chk("drop out_valid", 32'(OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("drop pulse end", 32'(ERR_DROP), 32'd0);
    chk("drop err_cnt", 32'(ERR_CNT), 32'(exp_cnt(1)));
    chk("drop fifo empty", 32'(OUT_FLIT), 32'd0);
    @(posedge CLK); #1;
    $display("single drop done err_cnt=%0d", ERR_CNT);

    // ---------------- 300 more drops: counter saturates ----------------
    drops = 0;
    for (int i = 0; i < 304; i++) begin
      IN_VALID = (i < 300);
      IN_FLIT = {($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 14'($urandom)};
      @(negedge CLK);
      if (ERR_DROP) drops++;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    chk("sat drop pulses", 32'(drops), 32'd300);
    chk("sat err_cnt", 32'(ERR_CNT), 32'(exp_cnt(301)));
    $display("saturation run done drops=%0d err_cnt=%0d", drops, ERR_CNT);

    // ---------------- randomized packets against the model ----------------
    begin
      int n_pkt = 40, n_stray = 0, idx = 0, done = 0, cyc = 0;
      stream.delete(); exp_flits.delete(); exp_route.delete();
      for (int p = 0; p < n_pkt; p++) begin
        int len, dx, dy;
        logic [15:0] f;
        if ($urandom_range(0, 4) == 0) begin
          stream.push_back({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 14'($urandom)});
          n_stray++;
        end
        len = $urandom_range(1, 4);
        dx = $urandom_range(0, 3); dy = $urandom_range(0, 3);
        f = {(len == 1) ? 2'b11 : 2'b01, 10'($urandom), 2'(dx), 2'(dy)};
        stream.push_back(f); exp_flits.push_back(f);
        exp_route.push_back(xy_route(dx, dy));
        for (int j = 1; j < len; j++) begin
          f = {(j == len - 1) ? 2'b10 : 2'b00, 14'($urandom)};
          stream.push_back(f); exp_flits.push_back(f);
        end
      end
      drops = 0;
      while ((idx < stream.size() || done < n_pkt) && cyc < 20000) begin
        IN_VALID  = (idx < stream.size()) && ($urandom_range(0, 9) < 7);
        IN_FLIT   = IN_VALID ? stream[idx] : 16'($urandom);
        GRANT     = ($urandom_range(0, 9) < 8);
        OUT_READY = ($urandom_range(0, 3) != 0);
        @(negedge CLK);
        if (IN_VALID && IN_READY) idx++;
        if (REQ_VALID) begin
          if (exp_route.size() == 0) chk("rnd unexpected request", 32'(REQ_VALID), 32'd0);
          else chk("rnd req_sw", 32'(REQ_SW), 32'(exp_route[0]));
        end
        if (OUT_VALID && OUT_READY) begin
          if (exp_flits.size() == 0) chk("rnd unexpected flit", 32'(OUT_VALID), 32'd0);
          else chk("rnd flit", 32'(OUT_FLIT), 32'(exp_flits.pop_front()));
        end
        if (CROSS_DONE) begin
          done++;
          if (exp_route.size() != 0) void'(exp_route.pop_front());
          $display("random packet %0d delivered at cycle %0d", done, cyc);
        end
        if (ERR_DROP) drops++;
        @(posedge CLK); #1;
        cyc++;
      end
      IN_VALID = 1'b0;
      chk("rnd within budget", 32'(cyc < 20000), 32'd1);
      chk("rnd packets done", 32'(done), 32'(n_pkt));
      chk("rnd stray drops", 32'(drops), 32'(n_stray));
      chk("rnd flits left", 32'(exp_flits.size()), 32'd0);
    end

    // ---------------- reset in the middle of a transfer ----------------
    GRANT = 1'b1; OUT_READY = 1'b0;
    stream = '{16'h4005, 16'h0123, 16'h8456};
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; IN_FLIT = stream[i];
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    wait_sig(1, "midrst reach xfer");
    RST = 1'b0;
    #1;
    check_idle_outputs("midrst");
    chk("midrst req_sw", 32'(REQ_SW), 32'd0);
    chk("midrst err_cnt", 32'(ERR_CNT), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK); RST = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle_outputs($sformatf("after midrst%0d", i));
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b1; IN_FLIT = 16'hC009;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_sig(0, "post-reset request");
    chk("post-reset req_sw", 32'(REQ_SW), 32'd1);
    @(posedge CLK); #1;
    wait_sig(1, "post-reset out_valid");
    chk("post-reset out_flit", 32'(OUT_FLIT), 32'hC009);
    @(posedge CLK); #1;
    wait_sig(2, "post-reset cross_done");
    @(posedge CLK); #1;
    @(negedge CLK);
    check_idle_outputs("post-reset idle");
    $display("mid-transfer reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
